// File: rtl/mem_req_responder.sv
// mem_req_responder: target side of the packed {addr, data, wr} memory-request
// interface. Requests land in a small FIFO, are serviced one at a time against
// a byte-wide register store, and each produces exactly one response. Writes
// into the low region [0, lock_top_i] are refused while lock_i is set.
module mem_req_responder #(
    parameter int DEPTH  = 16,
    parameter int QDEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [16:0] req_i,
    input  logic        lock_i,
    input  logic [7:0]  lock_top_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_wr_o,
    output logic        rsp_err_o
);

    // Pointer width is forced to at least one bit so a single-entry queue still
    // has a legal (constant-zero) pointer.
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QDEPTH);
    // Nine bits so DEPTH=256 is representable and never flags a range error.
    localparam logic [8:0]       DEPTH_LIM = 9'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;

    logic [16:0]       queue_q [QDEPTH];
    logic [16:0]       queue_d [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [16:0]       work_q, work_d;

    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic              rsp_err_q, rsp_err_d;

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];

    logic              push;
    logic              pop;
    logic              queue_empty;

    logic [7:0]        work_addr;
    logic [7:0]        work_data;
    logic              work_wr;
    logic [IDX_W-1:0]  mem_idx;
    logic              range_err;
    logic              lock_err;
    logic              acc_err;

    assign queue_empty = (count_q == '0);
    assign push        = req_valid_i && req_ready_o;

    assign work_addr = work_q[16:9];
    assign work_data = work_q[8:1];
    assign work_wr   = work_q[0];
    assign mem_idx   = work_addr[IDX_W-1:0];

    assign range_err = ({1'b0, work_addr} >= DEPTH_LIM);
    assign lock_err  = work_wr && lock_i && (work_addr <= lock_top_i);
    assign acc_err   = range_err || lock_err;

    // State register plus every other flop; reset drops queued and in-flight work
    // and clears the whole store.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            work_q     <= '0;
            rsp_data_q <= '0;
            rsp_wr_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            work_q     <= work_d;
            rsp_data_q <= rsp_data_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_err_q  <= rsp_err_d;
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state logic; also decides when the queue head is popped into the working register.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!queue_empty) begin
                    pop     = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (!queue_empty) begin
                        pop     = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request FIFO bookkeeping: push at the tail, pop the head into the working register.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            queue_d[i] = queue_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        work_d   = work_q;

        if (push) begin
            queue_d[wr_ptr_q] = req_i;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        if (pop) begin
            work_d   = queue_q[rd_ptr_q];
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Service the held request in the single ACCESS cycle; reads see the pre-write store.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        rsp_data_d = rsp_data_q;
        rsp_wr_d   = rsp_wr_q;
        rsp_err_d  = rsp_err_q;

        if (state_q == ACCESS) begin
            rsp_wr_d  = work_wr;
            rsp_err_d = acc_err;
            if (acc_err) begin
                rsp_data_d = 8'h00;
            end else if (work_wr) begin
                mem_d[mem_idx] = work_data;
                rsp_data_d     = work_data;
            end else begin
                rsp_data_d = mem_q[mem_idx];
            end
        end
    end

    // Outputs come straight from registers so they hold steady while the response stalls.
    always_comb begin
        req_ready_o = (count_q < CNT_FULL);
        rsp_valid_o = (state_q == RESP);
        rsp_data_o  = rsp_data_q;
        rsp_wr_o    = rsp_wr_q;
        rsp_err_o   = rsp_err_q;
    end

endmodule

// File: tb/tb_mem_req_responder.sv
// tb_mem_req_responder: directed table of single transactions plus hand-written
// sequences for latency, throughput, backpressure and mid-operation reset.
module tb_mem_req_responder;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [16:0] req_i;
    logic        lock_i;
    logic [7:0]  lock_top_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [7:0]  rsp_data_o;
    logic        rsp_wr_o;
    logic        rsp_err_o;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       lock;
        logic [7:0] top;
        logic [7:0] expData;
        logic       expWr;
        logic       expErr;
    } vec_t;

    typedef struct {
        int         cycle;
        logic [7:0] data;
        logic       wr;
        logic       err;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    rsp_t rspLog[$];
    vec_t vecs[$];

    mem_req_responder #(
        .DEPTH (16),
        .QDEPTH(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_i      (req_i),
        .lock_i     (lock_i),
        .lock_top_i (lock_top_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .rsp_wr_o   (rsp_wr_o),
        .rsp_err_o  (rsp_err_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Cycle counter used to measure response spacing.
    always @(posedge clk_i) begin
        cycle <= cycle + 1;
    end

    // Log every response handshake that the coming rising edge will complete.
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            rspLog.push_back('{cycle, rsp_data_o, rsp_wr_o, rsp_err_o});
        end
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Present one request and hold it until the responder accepts it; returns at edge+1.
    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data,
                                 input logic wr);
        bit accepted = 0;
        req_i       = {addr, data, wr};
        req_valid_i = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            accepted = req_ready_o;
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    // Pop the oldest logged response, waiting a bounded number of cycles for it.
    task automatic getRsp(output rsp_t r);
        for (int i = 0; i < 60 && rspLog.size() == 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        if (rspLog.size() == 0) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
            r = '{0, 8'h00, 1'b0, 1'b0};
        end else begin
            r = rspLog.pop_front();
        end
    endtask

    task automatic checkRsp(input string name, input rsp_t r, input logic [7:0] d,
                            input logic w, input logic e);
        checkOutput({name, ".data"}, 32'(r.data), 32'(d));
        checkOutput({name, ".wr"},   32'(r.wr),   32'(w));
        checkOutput({name, ".err"},  32'(r.err),  32'(e));
    endtask

    initial begin
        rsp_t r;
        rsp_t rs[4];
        vec_t v;

        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_i       = '0;
        lock_i      = 1'b0;
        lock_top_i  = 8'h00;
        rsp_ready_i = 1'b0;

        // Directed table, hand-computed against a store cleared by reset (DEPTH=16).
        vecs.push_back('{8'h03, 8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0});
        vecs.push_back('{8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{8'h10, 8'h77, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h0F, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h33, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h07, 8'h11, 1'b1, 1'b1, 8'h07, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h08, 8'h22, 1'b1, 1'b1, 8'h07, 8'h22, 1'b1, 1'b0});
        vecs.push_back('{8'h07, 8'h00, 1'b0, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'h08, 8'h00, 1'b0, 1'b1, 8'h07, 8'h22, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 8'h11, 1'b1, 1'b0, 8'h07, 8'h11, 1'b1, 1'b0});
        vecs.push_back('{8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h55, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h01, 8'h66, 1'b1, 1'b1, 8'h00, 8'h66, 1'b1, 1'b0});
        vecs.push_back('{8'h0F, 8'h99, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h0F, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'h0F, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{8'h0F, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0});

        // Two-cycle reset, then the idle output state.
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkOutput("reset.rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset.rsp_data",  32'(rsp_data_o),  32'd0);
        checkOutput("reset.rsp_wr",    32'(rsp_wr_o),    32'd0);
        checkOutput("reset.rsp_err",   32'(rsp_err_o),   32'd0);
        checkOutput("reset.req_ready", 32'(req_ready_o), 32'd1);

        // Latency: read of 0x05 shows valid only after the second edge past acceptance.
        $display("[TB] latency sequence");
        applyStimulus(8'h05, 8'h00, 1'b0);
        checkOutput("lat.e0_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("lat.e1_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("lat.e2_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("lat.e2_data",  32'(rsp_data_o),  32'h00);
        checkOutput("lat.e2_err",   32'(rsp_err_o),   32'd0);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("lat.after_hs_valid", 32'(rsp_valid_o), 32'd0);
        rspLog.delete();

        // Table-driven single transactions with the response side always ready.
        $display("[TB] vector table");
        for (int i = 0; i < vecs.size(); i++) begin
            v          = vecs[i];
            lock_i     = v.lock;
            lock_top_i = v.top;
            applyStimulus(v.addr, v.data, v.wr);
            getRsp(r);
            checkRsp($sformatf("vec%0d", i), r, v.expData, v.expWr, v.expErr);
        end
        lock_i     = 1'b0;
        lock_top_i = 8'h00;

        // Throughput: back-to-back requests drain one response every two cycles, in order.
        $display("[TB] throughput sequence");
        rspLog.delete();
        applyStimulus(8'h04, 8'h44, 1'b1);
        applyStimulus(8'h04, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h55, 1'b1);
        applyStimulus(8'h05, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            getRsp(rs[i]);
        end
        checkRsp("tput0", rs[0], 8'h44, 1'b1, 1'b0);
        checkRsp("tput1", rs[1], 8'h44, 1'b0, 1'b0);
        checkRsp("tput2", rs[2], 8'h55, 1'b1, 1'b0);
        checkRsp("tput3", rs[3], 8'h55, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("tput.spacing%0d", i),
                        32'(rs[i].cycle - rs[i-1].cycle), 32'd2);
        end

        // Backpressure: stalled response fills the queue, then releases in order.
        $display("[TB] backpressure sequence");
        rsp_ready_i = 1'b0;
        rspLog.delete();
        applyStimulus(8'h09, 8'h91, 1'b1);
        applyStimulus(8'h0A, 8'hA2, 1'b1);
        applyStimulus(8'h09, 8'h00, 1'b0);
        checkOutput("bp.full_ready", 32'(req_ready_o), 32'd0);
        req_i       = {8'h0B, 8'hB3, 1'b1};
        req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("bp.stall%0d_ready", i), 32'(req_ready_o), 32'd0);
            checkOutput($sformatf("bp.stall%0d_valid", i), 32'(rsp_valid_o), 32'd1);
            checkOutput($sformatf("bp.stall%0d_data", i),  32'(rsp_data_o),  32'h91);
        end
        checkOutput("bp.no_rsp_while_stalled", 32'(rspLog.size()), 32'd0);
        rsp_ready_i = 1'b1;
        applyStimulus(8'h0B, 8'hB3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            getRsp(rs[i]);
        end
        checkRsp("bp0", rs[0], 8'h91, 1'b1, 1'b0);
        checkRsp("bp1", rs[1], 8'hA2, 1'b1, 1'b0);
        checkRsp("bp2", rs[2], 8'h91, 1'b0, 1'b0);
        checkRsp("bp3", rs[3], 8'hB3, 1'b1, 1'b0);

        // Reset mid-operation: queued and in-flight work vanishes and storage clears.
        $display("[TB] mid-operation reset sequence");
        rsp_ready_i = 1'b0;
        rspLog.delete();
        applyStimulus(8'h01, 8'hE1, 1'b1);
        applyStimulus(8'h02, 8'hE2, 1'b1);
        applyStimulus(8'h03, 8'hE3, 1'b1);
        checkOutput("mr.pre_valid", 32'(rsp_valid_o), 32'd1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkOutput("mr.valid",     32'(rsp_valid_o), 32'd0);
        checkOutput("mr.data",      32'(rsp_data_o),  32'h00);
        checkOutput("mr.req_ready", 32'(req_ready_o), 32'd1);
        rsp_ready_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("mr.no_stale_rsp", 32'(rspLog.size()), 32'd0);
        applyStimulus(8'h01, 8'h00, 1'b0);
        getRsp(r);
        checkRsp("mr.read01", r, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h03, 8'h00, 1'b0);
        getRsp(r);
        checkRsp("mr.read03", r, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Responder (target) side of the packed memory-request interface {addr[7:0], data[7:0], wr}.
- Accepts requests through a valid/ready handshake into a small request queue and services them against an internal byte-wide register store.
- Returns one response per request through a valid/ready handshake.
- Includes a lock-protected low address region: writes into it are refused with an error while lock is set.

Parameters:
DEPTH, 16, number of 8-bit storage entries (1..256); addr >= DEPTH is out of range
QDEPTH, 2, request queue entries (>=1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  synchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request ready (queue not full)
req_i  input  17  packed request: [16:9]=addr, [8:1]=data, [0]=wr
lock_i  input  1  write protection enable, sampled in ACCESS
lock_top_i  input  8  highest protected address (inclusive)
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response ready
rsp_data_o  output  8  read data, or write data echo; 0 on error
rsp_wr_o  output  1  wr bit of the serviced request
rsp_err_o  output  1  request refused (out of range or locked write)

Behaviour:
- Reset (rst_ni=0 at an edge):
  - queue emptied; FSM goes to IDLE; all storage entries cleared to 0x00.
  - rsp_valid_o=0, rsp_data_o=0, rsp_wr_o=0, rsp_err_o=0; req_ready_o=1 the cycle after.
  - Reset mid-transaction drops queued and in-flight requests; no response is ever issued for them.
- Request handshake:
  - Transfer on a rising edge when req_valid_i & req_ready_o.
  - req_ready_o = (count < QDEPTH), driven from registered count only; no combinational path from req_valid_i.
  - Queue is FIFO order; no bypass.
- FSM states IDLE, ACCESS, RESP:
  - IDLE: queue non-empty -> pop head into the working register, go to ACCESS. Otherwise stay.
  - ACCESS (exactly one cycle): evaluate the held request, load response registers, go to RESP.
    - err = (addr >= DEPTH) | (wr & lock_i & addr <= lock_top_i).
    - wr & !err: mem[addr] <= data; rsp_data <= data.
    - !wr & !err: rsp_data <= mem[addr], the value before any write this same edge.
    - err: rsp_data <= 0; storage unchanged.
    - rsp_wr <= wr; rsp_err <= err.
  - RESP: rsp_valid_o=1; outputs held stable until rsp_ready_i.
    - On handshake, if queue non-empty: pop and go to ACCESS directly. Otherwise go to IDLE.
    - rsp_valid_o deasserts after handshake unless re-entering RESP later.
- Latency:
  - Request accepted at edge E0 with empty queue and FSM IDLE -> ACCESS after E1, rsp_valid_o high after E2.
  - Sustained throughput with rsp_ready_i=1: one response per 2 cycles.
- Simultaneous push and pop in the same edge is legal (count unchanged), including when count==QDEPTH-1.
- When full, req_ready_o=0 and no push occurs. A pop that edge makes ready high the next cycle.
- Order: responses are issued strictly in request order. A read following a write to the same address returns the new data.
- Address width: compare in full 8 bits; DEPTH=256 never produces a range error.
- lock_i/lock_top_i are sampled only in the ACCESS cycle. Changes while a request is queued affect that request.

Test Plan:
- Reset clears storage: assert rst_ni=0 for 2 cycles, then read addr 0x05 -> rsp_valid_o 2 edges after acceptance, rsp_data_o=0x00, rsp_err_o=0.
- Write/readback: write addr 0x03 data 0xA5, then read 0x03 with rsp_ready_i=1 -> responses {wr=1,data=0xA5,err=0} then {wr=0,data=0xA5,err=0}, spaced 2 cycles apart.
- Out of range (DEPTH=16): write addr 0x10 data 0x77, then read 0x10 -> both err=1, data=0x00. A read of 0x0F is unchanged by the write.
- Lock: lock_i=1, lock_top_i=0x07. Write 0x07<-0x11 gives err=1; write 0x08<-0x22 gives err=0. Reads of 0x07/0x08 return 0x00/0x22.
- Backpressure/full (QDEPTH=2): hold rsp_ready_i=0, send 4 requests -> req_ready_o drops after the queue fills (1 in RESP, 2 queued). rsp_data_o stays stable. Releasing rsp_ready_i drains all 4 responses in order.
- Reset mid-operation: 2 requests queued, rsp_valid_o=1, pulse rst_ni=0 for 1 cycle -> rsp_valid_o=0 next cycle, no further responses, storage reads 0x00.
